// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I controller: state codes, opcodes,
// ALU operation classes and the datapath mux select values.
package riscv_ctrl_pkg;

    localparam logic [3:0] ST_FETCH    = 4'd0;
    localparam logic [3:0] ST_DECODE   = 4'd1;
    localparam logic [3:0] ST_MEMADR   = 4'd2;
    localparam logic [3:0] ST_MEMREAD  = 4'd3;
    localparam logic [3:0] ST_MEMWB    = 4'd4;
    localparam logic [3:0] ST_MEMWRITE = 4'd5;
    localparam logic [3:0] ST_EXEC_R   = 4'd6;
    localparam logic [3:0] ST_EXEC_I   = 4'd7;
    localparam logic [3:0] ST_ALUWB    = 4'd8;
    localparam logic [3:0] ST_BEQ      = 4'd9;
    localparam logic [3:0] ST_JAL      = 4'd10;
    localparam logic [3:0] ST_TRAP     = 4'd11;

    // Typed view of the state codes above, handy in waveform viewers.
    typedef enum logic [3:0] {
        FETCH    = ST_FETCH,
        DECODE   = ST_DECODE,
        MEMADR   = ST_MEMADR,
        MEMREAD  = ST_MEMREAD,
        MEMWB    = ST_MEMWB,
        MEMWRITE = ST_MEMWRITE,
        EXEC_R   = ST_EXEC_R,
        EXEC_I   = ST_EXEC_I,
        ALUWB    = ST_ALUWB,
        BEQ      = ST_BEQ,
        JAL      = ST_JAL,
        TRAP     = ST_TRAP
    } state_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_e;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_SLL = 3'b010;
    localparam logic [2:0] ALU_SRA = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SRL = 3'b101;
    localparam logic [2:0] ALU_OR  = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b111;

endpackage

// File: rtl/alu_op_decoder.sv
// Combinational ALU decoder: maps the FSM's operation class plus the
// instruction's funct fields onto a concrete alu_control code.
module alu_op_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    output logic [2:0] alu_control
);

    // Immediate forms reuse IR[30] as immediate data, so SUB needs op5 as well.
    always_comb begin
        alu_control = ALU_ADD;
        case (aluop)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_control = ALU_SLL;
                    3'b100:  alu_control = ALU_XOR;
                    3'b101:  alu_control = funct7b5 ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Moore sequencing controller for the multicycle RV32I datapath.
// Define MCFSM_JAL_EN to include the JAL state; otherwise JAL traps.
module multicycle_ctrl_fsm
    import riscv_ctrl_pkg::*;
#(
    parameter int INSTRET_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [6:0]           opcode,
    input  logic [2:0]           funct3,
    input  logic                 funct7b5,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 pc_write,
    output logic                 adr_src,
    output logic                 mem_write,
    output logic                 ir_write,
    output logic [1:0]           result_src,
    output logic [1:0]           alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           imm_src,
    output logic                 reg_write,
    output logic [2:0]           alu_control,
    output logic                 illegal_instr,
    output logic [INSTRET_W-1:0] instret,
    output logic [3:0]           state_o
);

    logic [3:0] state_q;
    logic [3:0] state_d;
    logic [1:0] aluop;
    logic       retire;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH:    if (mem_ready) state_d = ST_DECODE;
            ST_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = ST_MEMADR;
                    OP_RTYPE:          state_d = ST_EXEC_R;
                    OP_ITYPE:          state_d = ST_EXEC_I;
                    OP_BRANCH:         state_d = ST_BEQ;
`ifdef MCFSM_JAL_EN
                    OP_JAL:            state_d = ST_JAL;
`endif
                    default:           state_d = ST_TRAP;
                endcase
            end
            ST_MEMADR:   state_d = (opcode == OP_STORE) ? ST_MEMWRITE : ST_MEMREAD;
            ST_MEMREAD:  if (mem_ready) state_d = ST_MEMWB;
            ST_MEMWB:    state_d = ST_FETCH;
            ST_MEMWRITE: if (mem_ready) state_d = ST_FETCH;
            ST_EXEC_R:   state_d = ST_ALUWB;
            ST_EXEC_I:   state_d = ST_ALUWB;
            ST_ALUWB:    state_d = ST_FETCH;
            ST_BEQ:      state_d = ST_FETCH;
`ifdef MCFSM_JAL_EN
            ST_JAL:      state_d = ST_ALUWB;
`endif
            ST_TRAP:     state_d = ST_TRAP;
            default:     state_d = ST_FETCH;
        endcase
    end

    // Write enables are squashed during reset so an aborted instruction leaves no trace.
    always_comb begin
        pc_write   = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        result_src = RES_ALUOUT;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RS2;
        aluop      = ALUOP_ADD;
        case (state_q)
            ST_FETCH: begin
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURESULT;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
            end
            ST_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
            end
            ST_MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
            end
            ST_MEMREAD: adr_src = 1'b1;
            ST_MEMWB: begin
                result_src = RES_DATA;
                reg_write  = 1'b1;
            end
            ST_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
            end
            ST_EXEC_R: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_RS2;
                aluop     = ALUOP_FUNCT;
            end
            ST_EXEC_I: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                aluop     = ALUOP_FUNCT;
            end
            ST_ALUWB: reg_write = 1'b1;
            ST_BEQ: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_RS2;
                aluop     = ALUOP_SUB;
                pc_write  = zero;
            end
`ifdef MCFSM_JAL_EN
            ST_JAL: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_FOUR;
                pc_write  = 1'b1;
            end
`endif
            default: ;
        endcase
        if (reset) begin
            pc_write  = 1'b0;
            ir_write  = 1'b0;
            mem_write = 1'b0;
            reg_write = 1'b0;
        end
    end

    always_comb begin
        case (opcode)
            OP_STORE:  imm_src = IMM_S;
            OP_BRANCH: imm_src = IMM_B;
            OP_JAL:    imm_src = IMM_J;
            default:   imm_src = IMM_I;
        endcase
    end

    assign retire = (state_q == ST_MEMWB) || (state_q == ST_ALUWB) || (state_q == ST_BEQ) ||
                    ((state_q == ST_MEMWRITE) && mem_ready);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_FETCH;
            instret       <= '0;
            illegal_instr <= 1'b0;
        end else begin
            state_q <= state_d;
            if (retire) instret <= instret + {{(INSTRET_W-1){1'b0}}, 1'b1};
            if (state_d == ST_TRAP) illegal_instr <= 1'b1;
        end
    end

    assign state_o = state_q;

    alu_op_decoder u_alu_op_decoder (
        .aluop       (aluop),
        .funct3      (funct3),
        .op5         (opcode[5]),
        .funct7b5    (funct7b5),
        .alu_control (alu_control)
    );

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed self-checking bench for multicycle_ctrl_fsm, built with a 4-bit
// retired-instruction counter so wraparound is reachable.
module tb_multicycle_ctrl_fsm;
    import riscv_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       mem_ready;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal_instr;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0] alu_control;
    logic [3:0] instret;
    logic [3:0] state_o;

    int         compared   = 0;
    int         mismatched = 0;
    logic [3:0] expInstret;

    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_LW   = 32'h0000A183;
    localparam logic [31:0] I_SW   = 32'h0020A223;
    localparam logic [31:0] I_BEQ  = 32'h00208463;
    localparam logic [31:0] I_JAL  = 32'h008000EF;

    always #5 clk = ~clk;

    multicycle_ctrl_fsm #(.INSTRET_W(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .funct3        (funct3),
        .funct7b5      (funct7b5),
        .zero          (zero),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .adr_src       (adr_src),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .result_src    (result_src),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .imm_src       (imm_src),
        .reg_write     (reg_write),
        .alu_control   (alu_control),
        .illegal_instr (illegal_instr),
        .instret       (instret),
        .state_o       (state_o)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input logic [31:0] ir, input logic rdy, input logic z);
        opcode    = ir[6:0];
        funct3    = ir[14:12];
        funct7b5  = ir[30];
        mem_ready = rdy;
        zero      = z;
        #1;
    endtask

    // One ALU instruction from FETCH back to FETCH, checking the decoded ALU op.
    task automatic runAlu(input string tag, input logic [31:0] ir, input logic [3:0] execState,
                          input logic [2:0] expAlu);
        applyStimulus(ir, 1'b1, 1'b0);
        checkOutput({tag, " fetch state"}, state_o, ST_FETCH);
        tick;
        tick;
        checkOutput({tag, " exec state"}, state_o, execState);
        checkOutput({tag, " alu_control"}, alu_control, expAlu);
        checkOutput({tag, " exec reg_write"}, reg_write, 0);
        tick;
        checkOutput({tag, " wb reg_write"}, reg_write, 1);
        tick;
        expInstret = expInstret + 4'd1;
        checkOutput({tag, " instret"}, instret, expInstret);
    endtask

    initial begin
        reset = 1'b1;
        expInstret = 4'd0;
        applyStimulus(I_ADD, 1'b1, 1'b0);
        tick;
        tick;
        checkOutput("reset state", state_o, ST_FETCH);
        checkOutput("reset pc_write forced", pc_write, 0);
        checkOutput("reset ir_write forced", ir_write, 0);
        checkOutput("reset instret", instret, 0);
        checkOutput("reset illegal", illegal_instr, 0);
        reset = 1'b0;

        // Fetch stalls while memory is not ready.
        applyStimulus(I_ADD, 1'b0, 1'b0);
        checkOutput("fetch stall ir_write", ir_write, 0);
        checkOutput("fetch stall pc_write", pc_write, 0);
        tick;
        checkOutput("fetch stall state", state_o, ST_FETCH);

        // add x3,x1,x2 walked state by state
        applyStimulus(I_ADD, 1'b1, 1'b0);
        checkOutput("add fetch ir_write", ir_write, 1);
        checkOutput("add fetch pc_write", pc_write, 1);
        checkOutput("add fetch srcb", alu_src_b, 2'b10);
        checkOutput("add fetch result_src", result_src, 2'b10);
        checkOutput("add fetch adr_src", adr_src, 0);
        tick;
        checkOutput("add decode state", state_o, ST_DECODE);
        checkOutput("add decode srca", alu_src_a, 2'b01);
        checkOutput("add decode srcb", alu_src_b, 2'b01);
        checkOutput("add decode ir_write", ir_write, 0);
        tick;
        checkOutput("add exec state", state_o, ST_EXEC_R);
        checkOutput("add exec alu", alu_control, 3'b000);
        checkOutput("add exec srca", alu_src_a, 2'b10);
        checkOutput("add exec srcb", alu_src_b, 2'b00);
        checkOutput("add exec reg_write", reg_write, 0);
        tick;
        checkOutput("add wb state", state_o, ST_ALUWB);
        checkOutput("add wb reg_write", reg_write, 1);
        checkOutput("add wb result_src", result_src, 2'b00);
        checkOutput("add wb instret", instret, 0);
        tick;
        checkOutput("add done state", state_o, ST_FETCH);
        checkOutput("add done instret", instret, 1);
        expInstret = 4'd1;

        runAlu("sub",       32'h402081B3, ST_EXEC_R, 3'b001);
        runAlu("addi b30",  32'h40008093, ST_EXEC_I, 3'b000);
        runAlu("srai",      32'h4030D093, ST_EXEC_I, 3'b011);
        runAlu("srl",       32'h0020D1B3, ST_EXEC_R, 3'b101);
        runAlu("sra",       32'h4020D1B3, ST_EXEC_R, 3'b011);
        runAlu("sll",       32'h002091B3, ST_EXEC_R, 3'b010);
        runAlu("xor",       32'h0020C1B3, ST_EXEC_R, 3'b100);
        runAlu("or",        32'h0020E1B3, ST_EXEC_R, 3'b110);
        runAlu("and",       32'h0020F1B3, ST_EXEC_R, 3'b111);
        runAlu("slt as add",32'h0020A1B3, ST_EXEC_R, 3'b000);

        // lw with three not-ready cycles in MEMREAD: 8 cycles total
        applyStimulus(I_LW, 1'b1, 1'b0);
        checkOutput("lw imm_src", imm_src, 2'b00);
        tick;
        tick;
        checkOutput("lw memadr state", state_o, ST_MEMADR);
        checkOutput("lw memadr srca", alu_src_a, 2'b10);
        checkOutput("lw memadr srcb", alu_src_b, 2'b01);
        applyStimulus(I_LW, 1'b0, 1'b0);
        tick;
        for (int i = 0; i < 3; i++) begin
            checkOutput("lw memread state", state_o, ST_MEMREAD);
            checkOutput("lw memread adr_src", adr_src, 1);
            tick;
        end
        checkOutput("lw memread 4th state", state_o, ST_MEMREAD);
        applyStimulus(I_LW, 1'b1, 1'b0);
        tick;
        checkOutput("lw memwb state", state_o, ST_MEMWB);
        checkOutput("lw memwb result_src", result_src, 2'b01);
        checkOutput("lw memwb reg_write", reg_write, 1);
        tick;
        expInstret = expInstret + 4'd1;
        checkOutput("lw done state", state_o, ST_FETCH);
        checkOutput("lw instret", instret, expInstret);

        // sw holding the write strobe through a memory wait
        applyStimulus(I_SW, 1'b1, 1'b0);
        checkOutput("sw imm_src", imm_src, 2'b01);
        tick;
        tick;
        applyStimulus(I_SW, 1'b0, 1'b0);
        tick;
        checkOutput("sw memwrite state", state_o, ST_MEMWRITE);
        checkOutput("sw mem_write", mem_write, 1);
        checkOutput("sw adr_src", adr_src, 1);
        tick;
        checkOutput("sw held mem_write", mem_write, 1);
        checkOutput("sw held instret", instret, expInstret);
        applyStimulus(I_SW, 1'b1, 1'b0);
        tick;
        expInstret = expInstret + 4'd1;
        checkOutput("sw done state", state_o, ST_FETCH);
        checkOutput("sw instret", instret, expInstret);

        // beq taken then not taken
        for (int z = 1; z >= 0; z--) begin
            applyStimulus(I_BEQ, 1'b1, 1'b0);
            checkOutput("beq imm_src", imm_src, 2'b10);
            tick;
            tick;
            applyStimulus(I_BEQ, 1'b1, z[0]);
            checkOutput("beq state", state_o, ST_BEQ);
            checkOutput("beq pc_write", pc_write, z[0]);
            checkOutput("beq alu", alu_control, 3'b001);
            tick;
            expInstret = expInstret + 4'd1;
            checkOutput("beq done state", state_o, ST_FETCH);
            checkOutput("beq instret", instret, expInstret);
        end

        applyStimulus(I_JAL, 1'b1, 1'b0);
        checkOutput("jal imm_src", imm_src, 2'b11);
        tick;
        tick;
`ifdef MCFSM_JAL_EN
        checkOutput("jal state", state_o, ST_JAL);
        checkOutput("jal pc_write", pc_write, 1);
        checkOutput("jal srca", alu_src_a, 2'b01);
        checkOutput("jal srcb", alu_src_b, 2'b10);
        tick;
        checkOutput("jal wb state", state_o, ST_ALUWB);
        checkOutput("jal wb reg_write", reg_write, 1);
        tick;
        expInstret = expInstret + 4'd1;
        checkOutput("jal instret", instret, expInstret);
`else
        checkOutput("jal disabled trap", state_o, ST_TRAP);
        checkOutput("jal disabled illegal", illegal_instr, 1);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        expInstret = 4'd0;
        runAlu("pre-trap add", I_ADD, ST_EXEC_R, 3'b000);
`endif

        // Unsupported opcode traps until reset
        applyStimulus(32'h00000000, 1'b1, 1'b0);
        tick;
        tick;
        checkOutput("trap state", state_o, ST_TRAP);
        checkOutput("trap illegal", illegal_instr, 1);
        checkOutput("trap pc_write", pc_write, 0);
        checkOutput("trap ir_write", ir_write, 0);
        checkOutput("trap mem_write", mem_write, 0);
        checkOutput("trap reg_write", reg_write, 0);
        tick;
        tick;
        checkOutput("trap sticky state", state_o, ST_TRAP);
        checkOutput("trap sticky illegal", illegal_instr, 1);
        checkOutput("trap instret frozen", instret, expInstret);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        checkOutput("post-trap state", state_o, ST_FETCH);
        checkOutput("post-trap illegal", illegal_instr, 0);
        checkOutput("post-trap instret", instret, 0);
        expInstret = 4'd0;

        // Reset while in MEMWRITE aborts the store uncounted
        runAlu("pre-abort add", I_ADD, ST_EXEC_R, 3'b000);
        applyStimulus(I_SW, 1'b1, 1'b0);
        tick;
        tick;
        applyStimulus(I_SW, 1'b0, 1'b0);
        tick;
        checkOutput("abort in memwrite", state_o, ST_MEMWRITE);
        reset = 1'b1;
        applyStimulus(I_SW, 1'b1, 1'b0);
        checkOutput("abort mem_write forced", mem_write, 0);
        tick;
        reset = 1'b0;
        checkOutput("abort state", state_o, ST_FETCH);
        checkOutput("abort instret", instret, 0);
        expInstret = 4'd0;

        // Sixteen retirements wrap the 4-bit counter back to zero
        for (int n = 0; n < 16; n++) runAlu("wrap add", I_ADD, ST_EXEC_R, 3'b000);
        checkOutput("instret wrapped", instret, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
